// File: rtl/feature_binarizer.sv
// rtl/feature_binarizer.sv - thresholds MFCC/flux samples into one Boolean feature vector per frame
// Optional BINARIZER_FRAME_CNT_EN adds a 16-bit handshaked-frame counter output.
module feature_binarizer #(
  parameter int N_MEL     = 32,
  parameter int BIT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_en_inf_system_sync,
  input  logic                     cfg_thr_we,
  input  logic                     cfg_thr_sel,
  input  logic [$clog2(N_MEL)-1:0] cfg_thr_addr,
  input  logic [BIT_WIDTH-1:0]     cfg_thr_data,
  input  logic                     valid_in,
  input  logic [BIT_WIDTH-1:0]     mfcc_data_in,
  input  logic [BIT_WIDTH-1:0]     flux_data_in,
  output logic                     ready_out,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [2*N_MEL-1:0]       frame_bits,
`ifdef BINARIZER_FRAME_CNT_EN
  output logic [15:0]              frame_cnt,
`endif
  output logic                     fifo_overflow
);

  localparam int AW = $clog2(N_MEL);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [BIT_WIDTH-1:0]   thr_m [N_MEL];
  logic [BIT_WIDTH-1:0]   thr_f [N_MEL];
  logic [BIT_WIDTH-1:0]   fifo_m [2];
  logic [BIT_WIDTH-1:0]   fifo_f [2];
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             count;
  logic [AW-1:0]          band;
  logic                   en, fifo_empty, fifo_full;
  logic                   push_req, push, pop, overflow_set;

  assign en         = spi_en_inf_system_sync;
  assign fifo_empty = (count == 2'd0);
  assign fifo_full  = (count == 2'd2);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop          = en && (state == COLLECT) && !fifo_empty;
  assign push_req     = en && valid_in;
  assign push         = push_req && (!fifo_full || pop);
  assign overflow_set = push_req && fifo_full && !pop;

  assign ready_out   = !rst && en && (state == COLLECT) && fifo_empty;
  assign frame_valid = (state == HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (pop && band == AW'(N_MEL - 1)) state_nxt = HOLD;
      HOLD:    if (frame_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_MEL; i++) begin
        thr_m[i] <= '0;
        thr_f[i] <= '0;
      end
    end else if (cfg_thr_we) begin
      if (cfg_thr_sel) thr_f[cfg_thr_addr] <= cfg_thr_data;
      else             thr_m[cfg_thr_addr] <= cfg_thr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_m[wr_ptr] <= mfcc_data_in;
      fifo_f[wr_ptr] <= flux_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      band          <= '0;
      count         <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      frame_bits    <= '0;
      fifo_overflow <= 1'b0;
    end else if (!en) begin
      state      <= COLLECT;
      band       <= '0;
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      frame_bits <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr                   <= ~rd_ptr;
        band                     <= band + 1'b1;
        frame_bits[band]         <= fifo_m[rd_ptr] > thr_m[band];
        frame_bits[{1'b1, band}] <= fifo_f[rd_ptr] > thr_f[band];
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (overflow_set) fifo_overflow <= 1'b1;
    end
  end

`ifdef BINARIZER_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || !en)                   frame_cnt <= '0;
    else if (frame_valid && frame_ready) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_feature_binarizer.sv
// tb/tb_feature_binarizer.sv - randomized scoreboard bench for feature_binarizer
module tb_feature_binarizer;
  localparam int N  = 32;
  localparam int W  = 16;
  localparam int AW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b1;
  logic           cfg_thr_we = 1'b0;
  logic           cfg_thr_sel = 1'b0;
  logic [AW-1:0]  cfg_thr_addr = '0;
  logic [W-1:0]   cfg_thr_data = '0;
  logic           valid_in = 1'b0;
  logic [W-1:0]   mfcc_data_in = '0;
  logic [W-1:0]   flux_data_in = '0;
  logic           ready_out, frame_valid, frame_ready, fifo_overflow;
  logic [2*N-1:0] frame_bits;
`ifdef BINARIZER_FRAME_CNT_EN
  logic [15:0]    frame_cnt;
`endif

  logic fr_direct = 1'b0, rand_ready_en = 1'b0, rnd_bit = 1'b0;
  assign frame_ready = rand_ready_en ? rnd_bit : fr_direct;

  always #5 clk = ~clk;

  feature_binarizer #(.N_MEL(N), .BIT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .spi_en_inf_system_sync(en),
    .cfg_thr_we(cfg_thr_we), .cfg_thr_sel(cfg_thr_sel),
    .cfg_thr_addr(cfg_thr_addr), .cfg_thr_data(cfg_thr_data),
    .valid_in(valid_in), .mfcc_data_in(mfcc_data_in), .flux_data_in(flux_data_in),
    .ready_out(ready_out), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_bits(frame_bits),
`ifdef BINARIZER_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .fifo_overflow(fifo_overflow)
  );

  int tests = 0, fails = 0, hs_count = 0;
  logic [2*N-1:0] exp_q[$];
  logic [W-1:0]   m_thr_m[N], m_thr_f[N];
  logic [2*N-1:0] m_frame = '0;
  int             m_band = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear(input bit clr_thr);
    m_frame = '0;
    m_band  = 0;
    if (clr_thr) for (int i = 0; i < N; i++) begin m_thr_m[i] = '0; m_thr_f[i] = '0; end
  endtask

  task automatic cfg(input bit sel, input int a, input logic [W-1:0] d);
    cfg_thr_we = 1'b1; cfg_thr_sel = sel; cfg_thr_addr = AW'(a); cfg_thr_data = d;
    tick();
    cfg_thr_we = 1'b0;
    if (sel) m_thr_f[a] = d; else m_thr_m[a] = d;
  endtask

  // Reference: the k-th accepted sample of a frame lands in band k.
  task automatic send(input logic [W-1:0] m, input logic [W-1:0] f);
    valid_in = 1'b1; mfcc_data_in = m; flux_data_in = f;
    m_frame[m_band]     = m > m_thr_m[m_band];
    m_frame[N + m_band] = f > m_thr_f[m_band];
    m_band++;
    if (m_band == N) begin
      exp_q.push_back(m_frame);
      m_band = 0;
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic send_drop(input logic [W-1:0] m, input logic [W-1:0] f);
    valid_in = 1'b1; mfcc_data_in = m; flux_data_in = f;
    tick();
    valid_in = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val(input logic [W-1:0] thr);
    case ($urandom_range(0, 3))
      0:       return thr;
      1:       return thr + W'(1);
      2:       return thr - W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send(rnd_val(m_thr_m[m_band]), rnd_val(m_thr_f[m_band]));
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!ready_out && k < 300) begin tick(); k++; end
    check(name, ready_out, 1);
  endtask

  task automatic wait_fv(input logic lvl, input string name);
    int k = 0;
    while (frame_valid !== lvl && k < 300) begin tick(); k++; end
    check(name, frame_valid, lvl);
  endtask

  // Monitor: pops the scoreboard on every frame handshake.
  initial begin
    logic           prev_fv;
    logic [2*N-1:0] prev_bits;
    prev_fv = 1'b0; prev_bits = '0;
    forever begin
      @(negedge clk);
      if (rst || !en) begin
        prev_fv  = 1'b0;
        hs_count = 0;
      end else begin
        if (frame_valid && prev_fv) check("hold_stable", frame_bits, prev_bits);
        if (frame_valid && frame_ready) begin
          if (exp_q.size() == 0) check("frame_expected", exp_q.size(), 1);
          else check("frame", frame_bits, exp_q.pop_front());
          hs_count++;
        end
        prev_fv   = frame_valid;
        prev_bits = frame_bits;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [2*N-1:0] snap;
    model_clear(1'b1);
    repeat (3) tick();
    check("rst_ready_low", ready_out, 0);
    rst = 1'b0;
    tick();
    check("reset_ready", ready_out, 1);
    check("reset_fv", frame_valid, 0);
    check("reset_bits", frame_bits, 0);
    check("reset_ovf", fifo_overflow, 0);

    // Zero thresholds, mfcc = band: every band except 0 exceeds.
    fr_direct = 1'b1;
    for (int b = 0; b < N; b++) send(W'(b), '0);
    check("t1_fv_t1", frame_valid, 0);
    tick();
    check("t1_fv_t2", frame_valid, 1);
    check("t1_bits", frame_bits, 64'h00000000_FFFFFFFE);
    tick();
    check("t1_fv_t3", frame_valid, 0);

    // Strict comparison at the threshold boundary.
    cfg(1'b0, 5, 16'h1000);
    cfg(1'b1, 5, 16'h0800);
    for (int r = 0; r < 2; r++) begin
      wait_ready("t2_ready");
      for (int b = 0; b < N; b++)
        send(b == 5 ? (r == 0 ? 16'h1000 : 16'h1001) : W'($urandom),
             b == 5 ? 16'h0801 : W'($urandom));
      tick();
      check("t2_bit5", frame_bits[5], r == 1);
      check("t2_bit37", frame_bits[37], 1);
    end

    // Frame held back while two samples queue up.
    wait_ready("t3_ready");
    fr_direct = 1'b0;
    send_rand(N);
    wait_fv(1'b1, "t3_fv_up");
    snap = frame_bits;
    send_rand(2);
    for (int i = 0; i < 18; i++) begin
      check("t3_ready_low", ready_out, 0);
      tick();
    end
    check("t3_bits_held", frame_bits, snap);
    check("t3_no_ovf", fifo_overflow, 0);
    fr_direct = 1'b1;
    wait_fv(1'b0, "t3_fv_down");
    send_rand(N - 2);

    // Third push into a full FIFO during HOLD is lost.
    wait_ready("t4_ready");
    fr_direct = 1'b0;
    send_rand(N);
    wait_fv(1'b1, "t4_fv_up");
    send_rand(2);
    check("t4_ovf_before", fifo_overflow, 0);
    send_drop(16'hABCD, 16'h1234);
    check("t4_ovf_set", fifo_overflow, 1);
    fr_direct = 1'b1;
    wait_fv(1'b0, "t4_fv_down");
    send_rand(N - 2);
    wait_ready("t4_ready2");
    send_rand(N);
    wait_ready("t4_ready3");
    check("t4_ovf_sticky", fifo_overflow, 1);

    // Disable mid-frame after band 16 has been binarized.
    for (int b = 0; b < 17; b++) send(16'hFFFF, 16'hFFFF);
    tick();
    check("t5_bit16", frame_bits[16], 1);
    en = 1'b0;
    model_clear(1'b0);
    tick();
    check("t5_bits_clr", frame_bits, 0);
    check("t5_fv_clr", frame_valid, 0);
    check("t5_ready_off", ready_out, 0);
    send_drop(16'hFFFF, 16'hFFFF);
    send_drop(16'hFFFF, 16'hFFFF);
    en = 1'b1;
    tick();
    check("t5_ready_on", ready_out, 1);
    check("t5_ovf_kept", fifo_overflow, 1);
    for (int b = 0; b < N; b++)
      send(b == 5 ? 16'h1000 : W'($urandom), b == 5 ? 16'h0800 : W'($urandom));
    tick();
    check("t5_thr_m_kept", frame_bits[5], 0);
    check("t5_thr_f_kept", frame_bits[37], 0);
    wait_ready("t5_ready2");
    check("t5_queue_drained", exp_q.size(), 0);

    // Reset clears overflow and thresholds.
    rst = 1'b1;
    tick();
    check("rst2_ready_low", ready_out, 0);
    rst = 1'b0;
    model_clear(1'b1);
    tick();
    check("rst2_ovf", fifo_overflow, 0);
    check("rst2_bits", frame_bits, 0);

    // Random thresholds, data, gaps and downstream backpressure.
    for (int i = 0; i < 40; i++) cfg(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), W'($urandom));
    rand_ready_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      wait_ready("rand_ready");
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send_rand(1);
      end
    end
    rand_ready_en = 1'b0;
    fr_direct = 1'b1;
    wait_ready("final_ready");
    check("final_queue_empty", exp_q.size(), 0);
    check("final_ovf", fifo_overflow, 0);
`ifdef BINARIZER_FRAME_CNT_EN
    check("frame_cnt", frame_cnt, 64'(hs_count));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
